// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream bus bundle for the frame generator output.
// Field widths follow the attached generator's DATA_WIDTH and USER_WIDTH.
interface axis_frame_gen_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  // Transmitter side: drives the beat, samples ready.
  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  // Receiver side: samples the beat, drives ready.
  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );

endinterface

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator for test and bring-up traffic.
// Sends cfg_frame_count frames (0 = until stop) of cfg_frame_len bytes,
// separated by cfg_gap idle cycles, with an optional bad-frame marker on tuser[0].
// Optional feature macro AXIS_FRAME_GEN_LFSR_EN: payload taken from an 8-bit
// Fibonacci LFSR (x^8+x^6+x^5+x^4+1) instead of the incrementing byte pattern.
module axis_frame_gen #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned USER_WIDTH  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [LEN_WIDTH-1:0]   cfg_frame_len,
  input  logic [COUNT_WIDTH-1:0] cfg_frame_count,
  input  logic [7:0]             cfg_gap,
  input  logic [7:0]             cfg_seed,
  input  logic                   cfg_mark_bad,
  axis_frame_gen_if.master       m_axis,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] frames_sent
);

  localparam logic [LEN_WIDTH-1:0] BEAT_BYTES = LEN_WIDTH'(KEEP_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                 state;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [7:0]             gap_q;
  logic                   mark_q;
  logic [LEN_WIDTH-1:0]   byte_idx;
  logic [7:0]             gap_cnt;
  logic                   stop_pending;

  logic [DATA_WIDTH-1:0]  tdata_q;
  logic [KEEP_WIDTH-1:0]  tkeep_q;
  logic                   tvalid_q;
  logic                   tlast_q;
  logic [USER_WIDTH-1:0]  tuser_q;

  logic                   hs;
  logic                   final_frame;
  logic [COUNT_WIDTH-1:0] frames_inc;
  logic [LEN_WIDTH-1:0]   src_len;
  logic                   src_mark;
  logic [LEN_WIDTH-1:0]   nxt_off;
  logic [LEN_WIDTH-1:0]   rem;
  logic                   nxt_last;
  logic [DATA_WIDTH-1:0]  nxt_data;
  logic [KEEP_WIDTH-1:0]  nxt_keep;
  logic [USER_WIDTH-1:0]  nxt_user;

`ifdef AXIS_FRAME_GEN_LFSR_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_walk;

  // One Fibonacci step: taps at bits 8,6,5,4 of the polynomial.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
`else
  logic [7:0] seed_q;
  logic [7:0] src_seed;
  logic [7:0] lane_base;
`endif

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;

  assign hs          = tvalid_q && m_axis.tready;
  assign frames_inc  = frames_sent + COUNT_WIDTH'(1);
  assign final_frame = ((count_q != '0) && (frames_inc == count_q)) || stop_pending || stop;

  // Build the beat that would be presented next: first beat of a frame from
  // IDLE (fresh config) or after a frame/gap, else the following beat in the frame.
  always_comb begin
    src_len  = (state == IDLE) ? cfg_frame_len : len_q;
    src_mark = (state == IDLE) ? cfg_mark_bad  : mark_q;
    nxt_off  = (state == SEND && !tlast_q) ? (byte_idx + BEAT_BYTES) : '0;
    rem      = src_len - nxt_off;
    nxt_last = (rem <= BEAT_BYTES);
    nxt_user = USER_WIDTH'(nxt_last && src_mark);
    nxt_data = '0;
    nxt_keep = '0;
`ifdef AXIS_FRAME_GEN_LFSR_EN
    lfsr_walk = (state == IDLE) ? ((cfg_seed == 8'h00) ? 8'hFF : cfg_seed) : lfsr_q;
`else
    src_seed  = (state == IDLE) ? cfg_seed : seed_q;
    lane_base = src_seed + 8'(nxt_off);
`endif
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      if (LEN_WIDTH'(i) < rem) begin
        nxt_keep[i] = 1'b1;
`ifdef AXIS_FRAME_GEN_LFSR_EN
        nxt_data[i*8 +: 8] = lfsr_walk;
        lfsr_walk          = lfsr_step(lfsr_walk);
`else
        nxt_data[i*8 +: 8] = lane_base + 8'(i);
`endif
      end
    end
  end

  // Frame sequencing FSM with registered stream outputs and status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_q        <= '0;
      count_q      <= '0;
      gap_q        <= '0;
      mark_q       <= 1'b0;
      byte_idx     <= '0;
      gap_cnt      <= '0;
      stop_pending <= 1'b0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      frames_sent  <= '0;
`ifdef AXIS_FRAME_GEN_LFSR_EN
      lfsr_q       <= '0;
`else
      seed_q       <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE && stop) begin
        stop_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          stop_pending <= 1'b0;
          if (start) begin
            len_q       <= cfg_frame_len;
            count_q     <= cfg_frame_count;
            gap_q       <= cfg_gap;
            mark_q      <= cfg_mark_bad;
            frames_sent <= '0;
`ifndef AXIS_FRAME_GEN_LFSR_EN
            seed_q      <= cfg_seed;
`endif
            if (cfg_frame_len == '0 || stop) begin
              done <= 1'b1;
            end else begin
              state    <= SEND;
              busy     <= 1'b1;
              tvalid_q <= 1'b1;
              tdata_q  <= nxt_data;
              tkeep_q  <= nxt_keep;
              tlast_q  <= nxt_last;
              tuser_q  <= nxt_user;
              byte_idx <= nxt_off;
`ifdef AXIS_FRAME_GEN_LFSR_EN
              lfsr_q   <= lfsr_walk;
`endif
            end
          end
        end

        SEND: begin
          if (hs) begin
            if (tlast_q) begin
              frames_sent <= frames_inc;
            end
            if (tlast_q && final_frame) begin
              state        <= IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
              stop_pending <= 1'b0;
              tvalid_q     <= 1'b0;
              tdata_q      <= '0;
              tkeep_q      <= '0;
              tlast_q      <= 1'b0;
              tuser_q      <= '0;
            end else if (tlast_q && gap_q != 8'd0) begin
              state    <= GAP;
              gap_cnt  <= gap_q - 8'd1;
              tvalid_q <= 1'b0;
              tdata_q  <= '0;
              tkeep_q  <= '0;
              tlast_q  <= 1'b0;
              tuser_q  <= '0;
            end else begin
              tdata_q  <= nxt_data;
              tkeep_q  <= nxt_keep;
              tlast_q  <= nxt_last;
              tuser_q  <= nxt_user;
              byte_idx <= nxt_off;
`ifdef AXIS_FRAME_GEN_LFSR_EN
              lfsr_q   <= lfsr_walk;
`endif
            end
          end
        end

        GAP: begin
          if (stop_pending || stop) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            stop_pending <= 1'b0;
          end else if (gap_cnt == 8'd0) begin
            state    <= SEND;
            tvalid_q <= 1'b1;
            tdata_q  <= nxt_data;
            tkeep_q  <= nxt_keep;
            tlast_q  <= nxt_last;
            tuser_q  <= nxt_user;
            byte_idx <= nxt_off;
`ifdef AXIS_FRAME_GEN_LFSR_EN
            lfsr_q   <= lfsr_walk;
`endif
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: 8-bit and 32-bit instances, table of
// frame configurations plus hand sequences for reset mid-frame and LFSR payload.
module tb_axis_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start32, stop, tready, cfg_mark_bad;
  logic [15:0] cfg_frame_len, cfg_frame_count;
  logic [7:0]  cfg_gap, cfg_seed;
  logic        busy8, done8, busy32, done32;
  logic [15:0] fs8, fs32;

  always #5 clk = ~clk;

  axis_frame_gen_if #(.DATA_WIDTH(8))  if8 ();
  axis_frame_gen_if #(.DATA_WIDTH(32)) if32 ();

  assign if8.tready  = tready;
  assign if32.tready = tready;

  axis_frame_gen #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .stop(stop),
    .cfg_frame_len(cfg_frame_len), .cfg_frame_count(cfg_frame_count),
    .cfg_gap(cfg_gap), .cfg_seed(cfg_seed), .cfg_mark_bad(cfg_mark_bad),
    .m_axis(if8), .busy(busy8), .done(done8), .frames_sent(fs8)
  );

  axis_frame_gen #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .stop(stop),
    .cfg_frame_len(cfg_frame_len), .cfg_frame_count(cfg_frame_count),
    .cfg_gap(cfg_gap), .cfg_seed(cfg_seed), .cfg_mark_bad(cfg_mark_bad),
    .m_axis(if32), .busy(busy32), .done(done32), .frames_sent(fs32)
  );

  // Monitor view of whichever instance is under test.
  logic        use32;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid, m_last, m_user, m_busy, m_done;
  logic [15:0] m_fs;

  always_comb begin
    if (use32) begin
      m_data = if32.tdata;  m_keep = if32.tkeep;  m_valid = if32.tvalid;
      m_last = if32.tlast;  m_user = if32.tuser[0];
      m_busy = busy32;      m_done = done32;      m_fs = fs32;
    end else begin
      m_data = {24'h0, if8.tdata}; m_keep = {3'b0, if8.tkeep}; m_valid = if8.tvalid;
      m_last = if8.tlast;   m_user = if8.tuser[0];
      m_busy = busy8;       m_done = done8;       m_fs = fs8;
    end
  end

  typedef struct {
    bit          w32;
    logic [15:0] len;
    logic [15:0] count;
    logic [7:0]  gap;
    logic [7:0]  seed;
    bit          mark;
    logic [3:0]  rdy;        // tready in cycle c = rdy[c % 4]
    int          stop_at;    // cycle of stop pulse, 0 = with start, -1 = none
    int          restart_at; // cycle of an extra start pulse while busy, -1 = none
    int          exp_beats;
    logic [15:0] exp_frames;
    logic [31:0] exp_first;
    logic [3:0]  exp_last_keep;
  } vec_t;

  vec_t        vecs [9];
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  got_bytes [$];

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          kw, off, rem, lanes, nb, done_cyc;
    logic [7:0]  ml;
    logic [31:0] ed, first_d;
    logic [3:0]  ek, last_k;
    bit          el, stalled, held_l, held_u;
    logic [31:0] held_d;
    logic [3:0]  held_k;
    int          hs_cyc [$];
    bit          hs_last [$];
    string       tag;

    tag      = $sformatf("v%0d", id);
    kw       = v.w32 ? 4 : 1;
    off      = 0;
    nb       = 0;
    done_cyc = -1;
    stalled  = 1'b0;
    first_d  = '0;
    last_k   = '0;
    held_d   = '0; held_k = '0; held_l = 1'b0; held_u = 1'b0;
    ml       = (v.seed == 8'h00) ? 8'hFF : v.seed;
    got_bytes.delete();

    @(negedge clk);
    use32           = v.w32;
    cfg_frame_len   = v.len;
    cfg_frame_count = v.count;
    cfg_gap         = v.gap;
    cfg_seed        = v.seed;
    cfg_mark_bad    = v.mark;
    tready          = v.rdy[0];
    stop            = (v.stop_at == 0);
    if (v.w32) start32 = 1'b1; else start8 = 1'b1;

    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      @(negedge clk);
      start8  = 1'b0;
      start32 = 1'b0;
      stop    = (c == v.stop_at);
      if (c == v.restart_at) begin
        cfg_frame_len = v.len + 16'd3;
        cfg_seed      = v.seed + 8'h55;
        if (v.w32) start32 = 1'b1; else start8 = 1'b1;
      end
      tready = v.rdy[c % 4];

      if (stalled) begin
        chk({tag, " hold_valid"}, m_valid, 1'b1);
        chk({tag, " hold_data"},  m_data,  held_d);
        chk({tag, " hold_keep"},  m_keep,  held_k);
        chk({tag, " hold_last"},  m_last,  held_l);
        chk({tag, " hold_user"},  m_user,  held_u);
      end
      stalled = 1'b0;

      if (m_valid && tready) begin
        rem   = int'(v.len) - off;
        lanes = (rem < kw) ? rem : kw;
        el    = (rem <= kw);
        ed    = '0;
        ek    = '0;
        for (int l = 0; l < lanes; l++) begin
          ek[l] = 1'b1;
`ifdef AXIS_FRAME_GEN_LFSR_EN
          ed[l*8 +: 8] = ml;
          ml = lfsr_step(ml);
`else
          ed[l*8 +: 8] = v.seed + 8'(off + l);
`endif
        end
        chk($sformatf("%s beat%0d data", tag, nb), m_data, ed);
        chk($sformatf("%s beat%0d keep", tag, nb), m_keep, ek);
        chk($sformatf("%s beat%0d last", tag, nb), m_last, el);
        chk($sformatf("%s beat%0d user", tag, nb), m_user, el && v.mark);
        if (nb == 0) first_d = m_data;
        last_k = m_keep;
        got_bytes.push_back(m_data[7:0]);
        hs_cyc.push_back(c);
        hs_last.push_back(el);
        off = el ? 0 : off + lanes;
        nb++;
      end else if (m_valid) begin
        stalled = 1'b1;
        held_d = m_data; held_k = m_keep; held_l = m_last; held_u = m_user;
      end

      if (m_done) done_cyc = c;
    end

    chk({tag, " done_seen"}, done_cyc >= 0, 1'b1);
    chk({tag, " beats"}, nb, v.exp_beats);
    chk({tag, " done_cycle"}, done_cyc, (nb == 0) ? 1 : hs_cyc[nb-1] + 1);
    chk({tag, " frames_sent"}, m_fs, v.exp_frames);
    chk({tag, " busy_at_done"}, m_busy, 1'b0);
    if (nb > 0) begin
`ifndef AXIS_FRAME_GEN_LFSR_EN
      chk({tag, " first_data"}, first_d, v.exp_first);
`endif
      chk({tag, " last_keep"}, last_k, v.exp_last_keep);
      if (v.rdy == 4'hF) begin
        chk({tag, " first_latency"}, hs_cyc[0], 1);
        for (int i = 0; i + 1 < nb; i++) begin
          if (hs_last[i]) chk($sformatf("%s gap_after_beat%0d", tag, i),
                              hs_cyc[i+1] - hs_cyc[i], int'(v.gap) + 1);
        end
      end
    end
    @(negedge clk);
    chk({tag, " done_pulse_width"}, m_done, 1'b0);
    chk({tag, " idle_valid"}, m_valid, 1'b0);
  endtask

  initial begin
    // w32 len count gap seed mark rdy stop restart beats frames first last_keep
    vecs[0] = '{0, 16'd4, 16'd2, 8'd0, 8'h10, 0, 4'hF, -1,  3, 8, 16'd2, 32'h10,       4'h1};
    vecs[1] = '{1, 16'd6, 16'd1, 8'd0, 8'h00, 0, 4'hF, -1, -1, 2, 16'd1, 32'h03020100, 4'h3};
    vecs[2] = '{0, 16'd3, 16'd1, 8'd0, 8'h40, 0, 4'b0011, -1, -1, 3, 16'd1, 32'h40,    4'h1};
    vecs[3] = '{0, 16'd2, 16'd0, 8'd2, 8'h20, 0, 4'hF,  5, -1, 4, 16'd2, 32'h20,       4'h1};
    vecs[4] = '{0, 16'd5, 16'd1, 8'd0, 8'hFE, 1, 4'hF, -1, -1, 5, 16'd1, 32'hFE,       4'h1};
    vecs[5] = '{0, 16'd0, 16'd1, 8'd0, 8'h00, 0, 4'hF, -1, -1, 0, 16'd0, 32'h0,        4'h0};
    vecs[6] = '{1, 16'd8, 16'd2, 8'd1, 8'hF0, 0, 4'hF, -1, -1, 4, 16'd2, 32'hF3F2F1F0, 4'hF};
    vecs[7] = '{1, 16'd5, 16'd1, 8'd0, 8'h07, 1, 4'hF, -1, -1, 2, 16'd1, 32'h0A090807, 4'h1};
    vecs[8] = '{0, 16'd4, 16'd1, 8'd0, 8'h00, 0, 4'hF,  0, -1, 0, 16'd0, 32'h0,        4'h0};

    rst_n = 1'b0; start8 = 1'b0; start32 = 1'b0; stop = 1'b0; tready = 1'b0;
    cfg_frame_len = '0; cfg_frame_count = '0; cfg_gap = '0; cfg_seed = '0;
    cfg_mark_bad = 1'b0; use32 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset valid8",  if8.tvalid, 1'b0);
    chk("reset valid32", if32.tvalid, 1'b0);
    chk("reset busy8",   busy8, 1'b0);
    chk("reset done32",  done32, 1'b0);
    chk("reset fs8",     fs8, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset while the third beat of a frame is on the bus.
    @(negedge clk);
    use32 = 1'b0; cfg_frame_len = 16'd6; cfg_frame_count = 16'd1; cfg_gap = 8'd0;
    cfg_seed = 8'h30; cfg_mark_bad = 1'b1; tready = 1'b1; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
`ifndef AXIS_FRAME_GEN_LFSR_EN
    chk("rst_mid beat2 data", m_data, 32'h32);
`endif
    chk("rst_mid beat2 valid", m_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid valid", m_valid, 1'b0);
    chk("rst_mid last",  m_last, 1'b0);
    chk("rst_mid user",  m_user, 1'b0);
    chk("rst_mid data",  m_data, 32'h0);
    chk("rst_mid keep",  m_keep, 4'h0);
    chk("rst_mid busy",  m_busy, 1'b0);
    chk("rst_mid done",  m_done, 1'b0);
    chk("rst_mid fs",    m_fs, 16'd0);
    rst_n = 1'b1;
    run_vec(vecs[0], 10);

`ifdef AXIS_FRAME_GEN_LFSR_EN
    begin
      vec_t lv;
      logic [7:0] exp_seq [6];
      exp_seq = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
      lv = '{0, 16'd6, 16'd1, 8'd0, 8'h00, 0, 4'hF, -1, -1, 6, 16'd1, 32'hFF, 4'h1};
      run_vec(lv, 11);
      for (int i = 0; i < 6; i++)
        chk($sformatf("lfsr byte%0d", i), (i < got_bytes.size()) ? got_bytes[i] : 8'h00, exp_seq[i]);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
